score_bcd_counter: RTL and testbench

- Multi-digit BCD score counter with per-digit 7-segment decode for the game display path.
- Counts up on a dodge event and down on a crash event.
- Events are rising-edge detected, so a held input counts once.
- Tracks the best score since reset and flags overflow and underflow attempts to the game controller.

---
 rtl/score_pkg.sv | 15 +
 rtl/bcd_to_seg7.sv | 24 ++
 rtl/score_bcd_counter.sv | 83 ++++++++
 tb/tb_score_bcd_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared constants for the score counter and its 7-segment decode
package score_pkg;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: one BCD digit to active-high a..g segments, illegal codes dark
module bcd_to_seg7
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);
    // pure lookup; codes 10..15 cannot occur but decode to blank for safety
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: edge-triggered up/down BCD score with best tracking and 7-segment output
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int DIGITS        = 2,
    parameter int WRAP          = 1,
    parameter int BLANK_LEADING = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dodge,
    input  logic                      crash,
    input  logic                      clear,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]       seg,
    output logic [BCD_W*DIGITS-1:0]   best,
    output logic                      ovf,
    output logic                      unf
);
    localparam int W = BCD_W * DIGITS;

    logic         dodge_q, crash_q, ovf_q, ovf_d, unf_q, unf_d, up, dn;
    logic [W-1:0] bcd_q, bcd_d, best_q, best_d, inc, dec;
    logic [DIGITS:0] carry, borrow;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    genvar d;
    for (d = 0; d < DIGITS; d++) begin : g_dig
        logic [BCD_W-1:0] cur;
        logic [6:0]       raw;
        assign cur         = bcd_q[BCD_W*d +: BCD_W];
        assign carry[d+1]  = carry[d] & (cur == 4'd9);
        assign borrow[d+1] = borrow[d] & (cur == 4'd0);
        assign inc[BCD_W*d +: BCD_W] = !carry[d]  ? cur : (cur == 4'd9 ? 4'd0 : cur + 4'd1);
        assign dec[BCD_W*d +: BCD_W] = !borrow[d] ? cur : (cur == 4'd0 ? 4'd9 : cur - 4'd1);
        bcd_to_seg7 u_seg (.bcd(cur), .seg(raw));
        if (d == 0) begin : g_low
            assign seg[6:0] = raw;
        end else begin : g_high
            assign seg[7*d +: 7] = (BLANK_LEADING != 0 && bcd_q[W-1:BCD_W*d] == '0) ? SEG_BLANK : raw;
        end
    end

    // carry[DIGITS] means all nines, borrow[DIGITS] means zero; clear wins, simultaneous edges cancel
    always_comb begin
        up     = dodge & ~dodge_q;
        dn     = crash & ~crash_q;
        bcd_d  = clear      ? '0 :
                 (up && dn) ? bcd_q :
                 up         ? ((carry[DIGITS] && WRAP == 0) ? bcd_q : inc) :
                 dn         ? (borrow[DIGITS] ? bcd_q : dec) :
                              bcd_q;
        ovf_d  = ~clear & up & ~dn & carry[DIGITS];
        unf_d  = ~clear & dn & ~up & borrow[DIGITS];
        best_d = (bcd_d > best_q) ? bcd_d : best_q;
    end

    // state and edge history, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dodge_q <= 1'b0;
            crash_q <= 1'b0;
            bcd_q   <= '0;
            best_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            dodge_q <= dodge;
            crash_q <= crash;
            bcd_q   <= bcd_d;
            best_q  <= best_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bcd  = bcd_q;
    assign best = best_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;
endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: random and directed check of three score counter variants against an integer model
module tb_score_bcd_counter;
    logic clk = 1'b0, reset = 1'b1, dodge = 1'b0, crash = 1'b0, clear = 1'b0;
    logic [7:0]  bcd_o  [3];
    logic [7:0]  best_o [3];
    logic [13:0] seg_o  [3];
    logic        ovf_o  [3];
    logic        unf_o  [3];
    int total = 0, bad = 0;
    int score [3];
    int best_m [3];
    bit eo [3];
    bit eu [3];
    bit pd = 0, pc = 0;
    localparam logic [6:0] SEGT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                         7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

    always #5 clk = ~clk;

    score_bcd_counter #(.DIGITS(2), .WRAP(1), .BLANK_LEADING(0)) u_a (
        .clk(clk), .reset(reset), .dodge(dodge), .crash(crash), .clear(clear),
        .bcd(bcd_o[0]), .seg(seg_o[0]), .best(best_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]));
    score_bcd_counter #(.DIGITS(2), .WRAP(0), .BLANK_LEADING(0)) u_b (
        .clk(clk), .reset(reset), .dodge(dodge), .crash(crash), .clear(clear),
        .bcd(bcd_o[1]), .seg(seg_o[1]), .best(best_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]));
    score_bcd_counter #(.DIGITS(2), .WRAP(1), .BLANK_LEADING(1)) u_c (
        .clk(clk), .reset(reset), .dodge(dodge), .crash(crash), .clear(clear),
        .bcd(bcd_o[2]), .seg(seg_o[2]), .best(best_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [13:0] exp_seg(input int v, input bit blank);
        return {(blank && v < 10) ? 7'b0000000 : SEGT[v / 10], SEGT[v % 10]};
    endfunction

    task automatic model_reset();
        pd = 0;
        pc = 0;
        for (int i = 0; i < 3; i++) begin
            score[i] = 0; best_m[i] = 0; eo[i] = 0; eu[i] = 0;
        end
    endtask

    task automatic model_clock();
        bit up, dn;
        up = dodge && !pd;
        dn = crash && !pc;
        for (int i = 0; i < 3; i++) begin
            eo[i] = 0;
            eu[i] = 0;
            if (clear) score[i] = 0;
            else if (up && dn) score[i] = score[i];
            else if (up) begin
                if (score[i] == 99) begin
                    eo[i] = 1;
                    score[i] = (i == 1) ? 99 : 0;
                end else score[i]++;
            end else if (dn) begin
                if (score[i] == 0) eu[i] = 1;
                else score[i]--;
            end
            if (score[i] > best_m[i]) best_m[i] = score[i];
        end
        pd = dodge;
        pc = crash;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bcd%0d", i), 32'(bcd_o[i]), 32'(to_bcd(score[i])));
            chk($sformatf("best%0d", i), 32'(best_o[i]), 32'(to_bcd(best_m[i])));
            chk($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(eo[i]));
            chk($sformatf("unf%0d", i), 32'(unf_o[i]), 32'(eu[i]));
            chk($sformatf("seg%0d", i), 32'(seg_o[i]), 32'(exp_seg(score[i], i == 2)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_clock();
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_dodge();
        dodge = 1'b1; step();
        dodge = 1'b0; step();
    endtask

    task automatic pulse_crash();
        crash = 1'b1; step();
        crash = 1'b0; step();
    endtask

    // reset lands mid-cycle, well away from any clock edge
    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) pulse_dodge();
        chk("dir_bcd12", 32'(bcd_o[0]), 32'h12);
        chk("dir_seg12", 32'(seg_o[0]), {18'd0, 7'b0110000, 7'b1101101});
        async_reset();
        for (int k = 0; k < 5; k++) pulse_dodge();
        dodge = 1'b1;
        for (int k = 0; k < 10; k++) step();
        dodge = 1'b0;
        step();
        chk("dir_hold", 32'(bcd_o[0]), 32'h06);
        for (int k = 0; k < 3; k++) pulse_crash();
        chk("dir_crash", 32'(bcd_o[0]), 32'h03);
        chk("dir_best", 32'(best_o[0]), 32'h06);
        chk("dir_blank", 32'(seg_o[2][13:7]), 32'h0);
        for (int k = 0; k < 4; k++) pulse_crash();
        chk("dir_zero", 32'(bcd_o[0]), 32'h00);
        dodge = 1'b1;
        crash = 1'b1;
        step();
        chk("dir_both", 32'(bcd_o[0]), 32'h00);
        dodge = 1'b0;
        crash = 1'b0;
        step();
        for (int k = 0; k < 3; k++) pulse_dodge();
        dodge = 1'b1;
        clear = 1'b1;
        step();
        chk("dir_clear", 32'(bcd_o[0]), 32'h00);
        chk("dir_clrbest", 32'(best_o[0]), 32'h06);
        dodge = 1'b0;
        clear = 1'b0;
        step();
        dodge = 1'b1;
        async_reset();
        step();
        chk("dir_rel", 32'(bcd_o[0]), 32'h01);
        step();
        chk("dir_held", 32'(bcd_o[0]), 32'h01);
        dodge = 1'b0;
        step();
        for (int c = 0; c < 4800; c++) begin
            int ph;
            ph = (c / 600) % 3;
            clear = 1'b0;
            if (ph == 0) begin
                if ($urandom_range(0, 3) != 0) dodge = ~dodge;
                crash = ($urandom_range(0, 9) == 0);
            end else if (ph == 1) begin
                if ($urandom_range(0, 3) != 0) crash = ~crash;
                dodge = ($urandom_range(0, 9) == 0);
            end else begin
                dodge = 1'($urandom_range(0, 1));
                crash = 1'($urandom_range(0, 1));
                clear = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 699) == 0) async_reset();
            else step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
